// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done handshake and result bus for the multi-cycle mul/div sequencer
interface muldiv_if #(parameter int WIDTH = 16);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;
    modport master (output start, op, operand_a, operand_b,
                    input  busy, done, result_hi, result_lo, div_by_zero);
    modport slave  (input  start, op, operand_a, operand_b,
                    output busy, done, result_hi, result_lo, div_by_zero);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: unsigned shift-add multiply / restoring divide over one shared adder
module muldiv_sequencer #(parameter int WIDTH = 16) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic             op_q, zero_q, accept, last;
    logic [WIDTH-1:0] b_q, hi_q, lo_q, hi_nx, lo_nx;
    logic [WIDTH:0]   rem_sh, add_x, add_y, mul_sum;
    logic [WIDTH+1:0] sum;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    // Divide-by-zero still spends one RUN cycle so its done timing is E+1
    always_comb begin
        accept   = state == IDLE && bus.start;
        last     = state == RUN && (zero_q || count == CW'(WIDTH - 1));
        state_nx = accept ? RUN : last ? DONE : state == DONE ? IDLE : state;
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        add_x    = op_q ? rem_sh : {1'b0, hi_q};
        add_y    = op_q ? ~{1'b0, b_q} : {1'b0, b_q};
        sum      = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(op_q);
        mul_sum  = lo_q[0] ? sum[WIDTH:0] : {1'b0, hi_q};
        hi_nx    = op_q ? (sum[WIDTH+1] ? sum[WIDTH-1:0] : rem_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
        lo_nx    = op_q ? {lo_q[WIDTH-2:0], sum[WIDTH+1]} : {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= '0;
            op_q            <= 1'b0;
            zero_q          <= 1'b0;
            b_q             <= '0;
            hi_q            <= '0;
            lo_q            <= '0;
            bus.result_hi   <= '0;
            bus.result_lo   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q            <= bus.op;
                zero_q          <= bus.op && bus.operand_b == '0;
                b_q             <= bus.operand_b;
                hi_q            <= '0;
                lo_q            <= bus.operand_a;
                count           <= '0;
                bus.div_by_zero <= 1'b0;
            end else if (state == RUN) begin
                count <= count + CW'(1);
                hi_q  <= hi_nx;
                lo_q  <= lo_nx;
                if (last) begin
                    bus.result_hi   <= zero_q ? lo_q : hi_nx;
                    bus.result_lo   <= zero_q ? '1 : lo_nx;
                    bus.div_by_zero <= zero_q;
                end
            end
        end
    end
endmodule
